// File: rtl/jt93cx6.sv
// Microwire 93Cx6 serial EEPROM model: word/all programming with a busy period,
// sequential read and a same-clock dump port. The serial output is do_o because `do` is a keyword.
module jt93cx6 #(
  parameter int AW     = 6,
  parameter int DW     = 16,
  parameter int WR_CYC = 1024,
  parameter int SEQ_RD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          sk,
  input  logic          di,
  output logic          do_o,
  output logic          rdy,
  input  logic [AW-1:0] dump_addr,
  input  logic          dump_we,
  input  logic [DW-1:0] dump_din,
  output logic [DW-1:0] dump_dout,
  input  logic          dump_clr,
  output logic          dump_flag
);

  localparam int CMDW = AW + 2;
  localparam int CW   = $clog2((CMDW > DW) ? CMDW : DW) + 1;
  localparam int BW   = $clog2(WR_CYC + 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMDW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(WR_CYC);
  localparam logic [BW-1:0] BUSY_ONE  = BW'(1);

  typedef enum logic [2:0] {IDLE, CMD, READ, WDATA, BUSY} state_t;

  // NOTE: the storage array is never reset; it powers up erased (all ones) like the real part.
  logic [DW-1:0] mem_q [2**AW] = '{default: '1};

  state_t          state_q, state_d;
  logic            sk_l_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CMDW-2:0] cmd_q, cmd_d;
  logic [CMDW-1:0] cmd_word;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic            rd_do_q, rd_do_d;
  logic            rd_done_q, rd_done_d;
  logic            load_q, load_d;
  logic            ewen_q, ewen_d;
  logic            all_q, all_d;
  logic            hold_q, hold_d;
  logic            fill_q, fill_d;
  logic [AW-1:0]   fill_addr_q, fill_addr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            flag_q, flag_d;

  logic            sk_rise;
  logic            fill_last;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;

  assign sk_rise   = sk & ~sk_l_q;
  assign fill_last = (fill_addr_q == '1);
  assign cmd_word  = {cmd_q, di};

  always_comb begin
    // NOTE: every next-state value starts from its current value, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    sh_d        = sh_q;
    rd_do_d     = rd_do_q;
    rd_done_d   = rd_done_q;
    load_d      = 1'b0;
    ewen_d      = ewen_q;
    all_d       = all_q;
    hold_d      = hold_q;
    fill_d      = fill_q;
    fill_addr_d = fill_addr_q;
    bcnt_d      = bcnt_q;
    mem_we      = 1'b0;
    mem_wa      = addr_q;
    mem_wd      = sh_q;

    if (load_q) sh_d = mem_q[addr_q];
    if (!cs)    hold_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs && !hold_q && sk_rise && di) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end

      CMD: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (sk_rise) begin
          cmd_d = cmd_word[CMDW-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CMD_LAST) begin
            cnt_d   = '0;
            addr_d  = cmd_word[AW-1:0];
            state_d = IDLE;
            hold_d  = 1'b1;
            case (cmd_word[CMDW-1:CMDW-2])
              2'b10: begin
                state_d   = READ;
                hold_d    = 1'b0;
                rd_do_d   = 1'b0;
                rd_done_d = 1'b0;
                load_d    = 1'b1;
              end
              2'b01: if (ewen_q) begin
                state_d = WDATA;
                all_d   = 1'b0;
                hold_d  = 1'b0;
              end
              2'b11: if (ewen_q) begin
                mem_we  = 1'b1;
                mem_wa  = cmd_word[AW-1:0];
                mem_wd  = '1;
                state_d = BUSY;
                bcnt_d  = BUSY_LOAD;
                fill_d  = 1'b0;
                hold_d  = 1'b0;
              end
              default: begin
                case (cmd_word[AW-1:AW-2])
                  2'b11: ewen_d = 1'b1;
                  2'b00: ewen_d = 1'b0;
                  2'b10: if (ewen_q) begin
                    state_d     = BUSY;
                    bcnt_d      = BUSY_LOAD;
                    fill_d      = 1'b1;
                    fill_addr_d = '0;
                    sh_d        = '1;
                    hold_d      = 1'b0;
                  end
                  default: if (ewen_q) begin
                    state_d = WDATA;
                    all_d   = 1'b1;
                    hold_d  = 1'b0;
                  end
                endcase
              end
            endcase
          end
        end
      end

      READ: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (sk_rise) begin
          if (rd_done_q) begin
            rd_do_d = 1'b1;
          end else begin
            rd_do_d = sh_q[DW-1];
            sh_d    = {sh_q[DW-2:0], 1'b1};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == DATA_LAST) begin
              cnt_d = '0;
              if (SEQ_RD != 0) begin
                addr_d = addr_q + 1'b1;
                load_d = 1'b1;
              end else begin
                rd_done_d = 1'b1;
              end
            end
          end
        end
      end

      WDATA: begin
        if (!cs) begin
          state_d = IDLE;
        end else if (sk_rise) begin
          sh_d  = {sh_q[DW-2:0], di};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = BUSY;
            bcnt_d  = BUSY_LOAD;
            if (all_q) begin
              fill_d      = 1'b1;
              fill_addr_d = '0;
            end else begin
              fill_d = 1'b0;
              mem_we = 1'b1;
              mem_wa = addr_q;
              mem_wd = sh_d;
            end
          end
        end
      end

      BUSY: begin
        // Bulk fill writes one word per clk from sh_q while the busy timer runs.
        if (fill_q) begin
          mem_we      = 1'b1;
          mem_wa      = fill_addr_q;
          fill_addr_d = fill_addr_q + 1'b1;
          if (fill_last) fill_d = 1'b0;
        end
        if (bcnt_q <= BUSY_ONE && (!fill_q || fill_last)) begin
          state_d = IDLE;
        end else if (bcnt_q > BUSY_ONE) begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    flag_d = flag_q | mem_we;
    if (dump_clr) flag_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sk_l_q      <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      sh_q        <= '0;
      rd_do_q     <= 1'b1;
      rd_done_q   <= 1'b0;
      load_q      <= 1'b0;
      ewen_q      <= 1'b0;
      all_q       <= 1'b0;
      hold_q      <= 1'b0;
      fill_q      <= 1'b0;
      fill_addr_q <= '0;
      bcnt_q      <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sk_l_q      <= sk;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      rd_do_q     <= rd_do_d;
      rd_done_q   <= rd_done_d;
      load_q      <= load_d;
      ewen_q      <= ewen_d;
      all_q       <= all_d;
      hold_q      <= hold_d;
      fill_q      <= fill_d;
      fill_addr_q <= fill_addr_d;
      bcnt_q      <= bcnt_d;
      flag_q      <= flag_d;
    end
  end

  // The internal write is issued last so it wins a same-address collision with the dump port.
  always_ff @(posedge clk) begin
    if (dump_we) mem_q[dump_addr] <= dump_din;
    if (mem_we)  mem_q[mem_wa]    <= mem_wd;
    dump_dout <= mem_q[dump_addr];
  end

  assign rdy       = (state_q != BUSY);
  assign dump_flag = flag_q;

  always_comb begin
    do_o = 1'b1;
    if (state_q == BUSY)      do_o = ~cs;
    else if (state_q == READ) do_o = rd_do_q;
  end

endmodule

// File: tb/tb_jt93cx6.sv
// Directed bench for jt93cx6 (AW=6, DW=16, WR_CYC=64): a command vector table
// followed by hand-written sequences for bulk fills, aborts, busy status and reset.
module tb_jt93cx6;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int WR_CYC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs, sk, di;
  logic          do_o, rdy;
  logic [AW-1:0] dump_addr;
  logic          dump_we;
  logic [DW-1:0] dump_din;
  logic [DW-1:0] dump_dout;
  logic          dump_clr;
  logic          dump_flag;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  jt93cx6 #(.AW(AW), .DW(DW), .WR_CYC(WR_CYC), .SEQ_RD(1)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sk(sk), .di(di), .do_o(do_o), .rdy(rdy),
    .dump_addr(dump_addr), .dump_we(dump_we), .dump_din(dump_din),
    .dump_dout(dump_dout), .dump_clr(dump_clr), .dump_flag(dump_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rdy) busy_cnt++;

  typedef enum {OP_READ, OP_EWEN, OP_EWDS, OP_WRITE, OP_ERASE} op_e;

  typedef struct {
    op_e         op;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        clr;
    int          exp_low;
    logic [15:0] exp_rd;
    logic        exp_flag;
    logic [15:0] exp_mem;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sk_bit(input logic b, output logic dout);
    @(negedge clk); di = b; sk = 1'b1;
    @(negedge clk); dout = do_o;
    @(negedge clk); @(negedge clk); sk = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int n, output logic last);
    for (int i = n - 1; i >= 0; i--) sk_bit(v[i], last);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [5:0] a, output logic last);
    @(negedge clk); cs = 1'b1;
    send({23'b0, 1'b1, op, a}, 9, last);
  endtask

  task automatic end_cmd();
    @(negedge clk); cs = 1'b0; sk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_words(input logic [5:0] a, input int n, output logic [31:0] data,
                            output logic dummy);
    logic b;
    data = '0;
    start_cmd(2'b10, a, dummy);
    for (int i = 0; i < n * DW; i++) begin
      sk_bit(1'b0, b);
      data = {data[30:0], b};
    end
    end_cmd();
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", 32'(rdy), 32'h1);
  endtask

  task automatic dump_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk); dump_addr = a;
    @(negedge clk); d = dump_dout;
  endtask

  task automatic dump_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk); dump_addr = a; dump_din = d; dump_we = 1'b1;
    @(negedge clk); dump_we = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); dump_clr = 1'b1;
    @(negedge clk); dump_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] rd;
    logic        dm;
    logic [15:0] mw;
    int          base;
    if (v.clr) pulse_clr();
    base = busy_cnt;
    case (v.op)
      OP_READ: begin
        read_words(v.addr, 1, rd, dm);
        check($sformatf("v%0d dummy", idx), 32'(dm), 32'h0);
        check($sformatf("v%0d read", idx), rd, 32'(v.exp_rd));
      end
      OP_EWEN: begin start_cmd(2'b00, 6'h30, dm); end_cmd(); end
      OP_EWDS: begin start_cmd(2'b00, 6'h00, dm); end_cmd(); end
      OP_WRITE: begin
        start_cmd(2'b01, v.addr, dm);
        send(32'(v.data), DW, dm);
        end_cmd();
      end
      OP_ERASE: begin start_cmd(2'b11, v.addr, dm); end_cmd(); end
      default: ;
    endcase
    wait_rdy();
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt - base), 32'(v.exp_low));
    check($sformatf("v%0d dump_flag", idx), 32'(dump_flag), 32'(v.exp_flag));
    dump_read(v.addr, mw);
    check($sformatf("v%0d mem", idx), 32'(mw), 32'(v.exp_mem));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [15];
    logic [31:0] rd;
    logic [15:0] mw;
    logic        dm;
    int          base;

    vecs[0]  = '{OP_READ,  6'h05, 16'h0000, 1'b0, 0,  16'hFFFF, 1'b0, 16'hFFFF};
    vecs[1]  = '{OP_EWEN,  6'h00, 16'h0000, 1'b0, 0,  16'h0000, 1'b0, 16'hFFFF};
    vecs[2]  = '{OP_WRITE, 6'h0A, 16'h1234, 1'b0, 64, 16'h0000, 1'b1, 16'h1234};
    vecs[3]  = '{OP_READ,  6'h0A, 16'h0000, 1'b0, 0,  16'h1234, 1'b1, 16'h1234};
    vecs[4]  = '{OP_EWDS,  6'h0A, 16'h0000, 1'b1, 0,  16'h0000, 1'b0, 16'h1234};
    vecs[5]  = '{OP_WRITE, 6'h0A, 16'h0000, 1'b0, 0,  16'h0000, 1'b0, 16'h1234};
    vecs[6]  = '{OP_READ,  6'h0A, 16'h0000, 1'b0, 0,  16'h1234, 1'b0, 16'h1234};
    vecs[7]  = '{OP_ERASE, 6'h0A, 16'h0000, 1'b0, 0,  16'h0000, 1'b0, 16'h1234};
    vecs[8]  = '{OP_EWEN,  6'h0A, 16'h0000, 1'b0, 0,  16'h0000, 1'b0, 16'h1234};
    vecs[9]  = '{OP_WRITE, 6'h01, 16'h8001, 1'b0, 64, 16'h0000, 1'b1, 16'h8001};
    vecs[10] = '{OP_READ,  6'h01, 16'h0000, 1'b0, 0,  16'h8001, 1'b1, 16'h8001};
    vecs[11] = '{OP_ERASE, 6'h0A, 16'h0000, 1'b1, 64, 16'h0000, 1'b1, 16'hFFFF};
    vecs[12] = '{OP_READ,  6'h0A, 16'h0000, 1'b0, 0,  16'hFFFF, 1'b1, 16'hFFFF};
    vecs[13] = '{OP_WRITE, 6'h3E, 16'h0F0F, 1'b0, 64, 16'h0000, 1'b1, 16'h0F0F};
    vecs[14] = '{OP_READ,  6'h3E, 16'h0000, 1'b0, 0,  16'h0F0F, 1'b1, 16'h0F0F};

    rst = 1'b1; cs = 1'b0; sk = 1'b0; di = 1'b0;
    dump_addr = '0; dump_we = 1'b0; dump_din = '0; dump_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset do", 32'(do_o), 32'h1);
    check("reset rdy", 32'(rdy), 32'h1);
    check("reset dump_flag", 32'(dump_flag), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) apply(vecs[i], i);

    // Sequential read across the top address, preloaded via the dump port.
    pulse_clr();
    dump_write(6'h3F, 16'hAAAA);
    dump_write(6'h00, 16'h5555);
    check("dump_we no flag", 32'(dump_flag), 32'h0);
    read_words(6'h3F, 2, rd, dm);
    check("seq dummy", 32'(dm), 32'h0);
    check("seq wrap read", rd, 32'hAAAA5555);

    // WRITE-ALL then ERASE-ALL, every address inspected through the dump port.
    base = busy_cnt;
    start_cmd(2'b00, 6'h10, dm);
    send(32'hBEEF, DW, dm);
    end_cmd();
    wait_rdy();
    check("wral busy_cycles", 32'(busy_cnt - base), 32'(WR_CYC));
    check("wral dump_flag", 32'(dump_flag), 32'h1);
    for (int a = 0; a < 64; a++) begin
      dump_read(6'(a), mw);
      check($sformatf("wral mem[%0d]", a), 32'(mw), 32'hBEEF);
    end

    base = busy_cnt;
    start_cmd(2'b00, 6'h20, dm);
    end_cmd();
    wait_rdy();
    check("eral busy_cycles", 32'(busy_cnt - base), 32'(WR_CYC));
    for (int a = 0; a < 64; a++) begin
      dump_read(6'(a), mw);
      check($sformatf("eral mem[%0d]", a), 32'(mw), 32'hFFFF);
    end

    // WRITE aborted by deselect after five data bits.
    base = busy_cnt;
    start_cmd(2'b01, 6'h05, dm);
    send(32'h0, 5, dm);
    end_cmd();
    repeat (4) @(negedge clk);
    check("abort busy_cycles", 32'(busy_cnt - base), 32'h0);
    dump_read(6'h05, mw);
    check("abort mem", 32'(mw), 32'hFFFF);
    read_words(6'h05, 1, rd, dm);
    check("abort read dummy", 32'(dm), 32'h0);
    check("abort read", rd, 32'hFFFF);

    // Busy status on do while cs stays high, then ready status.
    base = busy_cnt;
    start_cmd(2'b01, 6'h07, dm);
    send(32'h1111, DW, dm);
    check("busy do", 32'(do_o), 32'h0);
    check("busy rdy", 32'(rdy), 32'h0);
    wait_rdy();
    check("ready do", 32'(do_o), 32'h1);
    end_cmd();
    check("write07 busy_cycles", 32'(busy_cnt - base), 32'(WR_CYC));
    dump_read(6'h07, mw);
    check("write07 mem", 32'(mw), 32'h1111);

    // Reset in the middle of an ERAL leaves a partial fill and disables writes.
    base = busy_cnt;
    start_cmd(2'b00, 6'h10, dm);
    send(32'h0, DW, dm);
    end_cmd();
    wait_rdy();
    check("wral0 busy_cycles", 32'(busy_cnt - base), 32'(WR_CYC));
    start_cmd(2'b00, 6'h20, dm);
    repeat (10) @(negedge clk);
    check("eral busy do", 32'(do_o), 32'h0);
    check("eral busy rdy", 32'(rdy), 32'h0);
    #3 rst = 1'b1;
    #1;
    check("midreset rdy", 32'(rdy), 32'h1);
    check("midreset do", 32'(do_o), 32'h1);
    @(negedge clk); rst = 1'b0; cs = 1'b0;
    repeat (2) @(negedge clk);
    dump_read(6'h00, mw);
    check("partial mem[0]", 32'(mw), 32'hFFFF);
    dump_read(6'h3F, mw);
    check("partial mem[63]", 32'(mw), 32'h0000);
    base = busy_cnt;
    start_cmd(2'b01, 6'h3F, dm);
    send(32'hFFFF, DW, dm);
    end_cmd();
    repeat (4) @(negedge clk);
    check("post-reset wr disabled", 32'(busy_cnt - base), 32'h0);
    read_words(6'h3F, 1, rd, dm);
    check("post-reset read dummy", 32'(dm), 32'h0);
    check("post-reset read", rd, 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
